wash_sequencer: RTL and testbench

//   Cycle controller for the washer. Sequences fill/wash/drain/rinse/spin phases from a 1-tick-per-second enable.

---
 rtl/wash_sequencer_if.sv | 28 ++
 rtl/wash_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_wash_sequencer.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wash_sequencer_if.sv
// Washer control bundle between the front panel / tick source and the
// cycle sequencer. The master side drives buttons, mode and tick; the
// sequencer (slave) drives the display and status signals.
interface wash_sequencer_if;
  logic       power_btn;
  logic       start_btn;
  logic [1:0] mode;
  logic       tick;
  logic       power_light;
  logic       running;
  logic [2:0] phase;
  logic [6:0] total_time;
  logic [6:0] current_time;
  logic [2:0] current_water;
  logic       buzzer;

  modport master (
    output power_btn, start_btn, mode, tick,
    input  power_light, running, phase, total_time, current_time,
           current_water, buzzer
  );

  modport slave (
    input  power_btn, start_btn, mode, tick,
    output power_light, running, phase, total_time, current_time,
           current_water, buzzer
  );
endinterface

// File: rtl/wash_sequencer.sv
// Washer cycle controller: sequences fill / wash / drain / rinse / spin from
// a once-per-second tick and drives the display values (power light, program
// total, remaining time, water level). All outputs are registered.
// Optional feature: define BUZZER_EN to get a completion buzzer that sounds
// for BUZZ_T ticks after the program finishes; otherwise buzzer is tied 0.
module wash_sequencer #(
  parameter int WATER_FULL = 5,
  parameter int WASH_T     = 9,
  parameter int RINSE_T    = 6,
  parameter int SPIN_T     = 3,
  parameter int BUZZ_T     = 5
) (
  input logic             clk,
  input logic             rst_n,
  wash_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    OFF   = 3'd0,
    IDLE  = 3'd1,
    FILL  = 3'd2,
    WASH  = 3'd3,
    DRAIN = 3'd4,
    RINSE = 3'd5,
    SPIN  = 3'd6,
    DONE  = 3'd7
  } state_t;

  // Full program is the longest; it has to fit the two display digits.
  localparam bit CFG_OK = (WATER_FULL >= 1) && (WATER_FULL <= 7) &&
                          (WASH_T >= 1) && (RINSE_T >= 1) && (SPIN_T >= 1) &&
                          (BUZZ_T >= 1) &&
                          (4 * WATER_FULL + WASH_T + RINSE_T + SPIN_T <= 99);

  if (!CFG_OK) begin : g_cfg_bad
    $error("wash_sequencer: parameter out of range");
  end

  state_t     state;
  logic       power_r;
  logic       running_r;
  logic       paused;
  logic       rinse_pass;
  logic [1:0] mode_r;
  logic [6:0] cnt;
  logic [6:0] total_r;
  logic [6:0] cur_r;
  logic [2:0] water_r;

  function automatic logic [6:0] prog_total(input logic [1:0] m);
    case (m)
      2'd0:    return 7'(4 * WATER_FULL + WASH_T + RINSE_T + SPIN_T);
      2'd1:    return 7'(2 * WATER_FULL + WASH_T);
      2'd2:    return 7'(2 * WATER_FULL + RINSE_T + SPIN_T);
      default: return 7'(SPIN_T);
    endcase
  endfunction

  function automatic logic [6:0] phase_len(input state_t s);
    case (s)
      FILL, DRAIN: return 7'(WATER_FULL);
      WASH:        return 7'(WASH_T);
      RINSE:       return 7'(RINSE_T);
      SPIN:        return 7'(SPIN_T);
      default:     return 7'd1;
    endcase
  endfunction

  // rinse_pass distinguishes the first FILL/DRAIN pair (wash) from the
  // second (rinse) in the full program.
  function automatic state_t next_phase(input state_t s, input logic [1:0] m,
                                        input logic rp);
    case (s)
      FILL:        return (m == 2'd2 || (m == 2'd0 && rp)) ? RINSE : WASH;
      WASH, RINSE: return DRAIN;
      DRAIN: begin
        if (m == 2'd1)             return DONE;
        else if (m == 2'd0 && !rp) return FILL;
        else                       return SPIN;
      end
      default:     return DONE;
    endcase
  endfunction

`ifdef BUZZER_EN
  logic       buzz_r;
  logic [6:0] buzz_cnt;
`endif

  // Main sequencer: power toggle has priority, then per-state handling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= OFF;
      power_r    <= 1'b0;
      running_r  <= 1'b0;
      paused     <= 1'b0;
      rinse_pass <= 1'b0;
      mode_r     <= 2'd0;
      cnt        <= 7'd0;
      total_r    <= 7'd0;
      cur_r      <= 7'd0;
      water_r    <= 3'd0;
`ifdef BUZZER_EN
      buzz_r     <= 1'b0;
      buzz_cnt   <= 7'd0;
`endif
    end else if (bus.power_btn) begin
      if (state == OFF) begin
        state   <= IDLE;
        power_r <= 1'b1;
        total_r <= prog_total(bus.mode);
        cur_r   <= prog_total(bus.mode);
      end else begin
        state      <= OFF;
        power_r    <= 1'b0;
        running_r  <= 1'b0;
        paused     <= 1'b0;
        rinse_pass <= 1'b0;
        mode_r     <= 2'd0;
        cnt        <= 7'd0;
        total_r    <= 7'd0;
        cur_r      <= 7'd0;
        water_r    <= 3'd0;
`ifdef BUZZER_EN
        buzz_r     <= 1'b0;
        buzz_cnt   <= 7'd0;
`endif
      end
    end else begin
      case (state)
        OFF: ;
        IDLE: begin
          total_r <= prog_total(bus.mode);
          cur_r   <= prog_total(bus.mode);
          if (bus.start_btn) begin
            mode_r     <= bus.mode;
            state      <= (bus.mode == 2'd3) ? SPIN : FILL;
            running_r  <= 1'b1;
            paused     <= 1'b0;
            rinse_pass <= 1'b0;
            cnt        <= 7'd0;
            water_r    <= 3'd0;
          end
        end
        DONE: begin
          if (bus.start_btn) begin
            state      <= IDLE;
            total_r    <= prog_total(bus.mode);
            cur_r      <= prog_total(bus.mode);
            rinse_pass <= 1'b0;
`ifdef BUZZER_EN
            buzz_r     <= 1'b0;
            buzz_cnt   <= 7'd0;
`endif
          end
`ifdef BUZZER_EN
          else if (bus.tick && buzz_r) begin
            buzz_cnt <= buzz_cnt + 7'd1;
            if (buzz_cnt + 7'd1 == 7'(BUZZ_T)) buzz_r <= 1'b0;
          end
`endif
        end
        default: begin
          // A start press in the same cycle as a tick swallows the tick.
          if (bus.start_btn) begin
            paused    <= !paused;
            running_r <= paused;
          end else if (bus.tick && !paused) begin
            cur_r <= cur_r - 7'd1;
            if (state == FILL)       water_r <= water_r + 3'd1;
            else if (state == DRAIN) water_r <= water_r - 3'd1;
            if (cnt + 7'd1 == phase_len(state)) begin
              cnt   <= 7'd0;
              state <= next_phase(state, mode_r, rinse_pass);
              if (state == DRAIN && mode_r == 2'd0) rinse_pass <= 1'b1;
              if (next_phase(state, mode_r, rinse_pass) == DONE) begin
                running_r <= 1'b0;
`ifdef BUZZER_EN
                buzz_r    <= 1'b1;
                buzz_cnt  <= 7'd0;
`endif
              end
            end else begin
              cnt <= cnt + 7'd1;
            end
          end
        end
      endcase
    end
  end

  assign bus.power_light   = power_r;
  assign bus.running       = running_r;
  assign bus.phase         = state;
  assign bus.total_time    = total_r;
  assign bus.current_time  = cur_r;
  assign bus.current_water = water_r;
`ifdef BUZZER_EN
  assign bus.buzzer        = buzz_r;
`else
  assign bus.buzzer        = 1'b0;
`endif

endmodule

// File: tb/tb_wash_sequencer.sv
// Bench for wash_sequencer: a phase-list reference model predicts every
// output after each clock; predictions are queued when inputs are driven
// and popped for comparison once the edge has been taken.
module tb_wash_sequencer;

  localparam int WF      = 5;
  localparam int WASH_T  = 9;
  localparam int RINSE_T = 6;
  localparam int SPIN_T  = 3;
  localparam int BUZZ_T  = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wash_sequencer_if bus ();

  wash_sequencer #(
    .WATER_FULL(WF), .WASH_T(WASH_T), .RINSE_T(RINSE_T),
    .SPIN_T(SPIN_T), .BUZZ_T(BUZZ_T)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic       pl;
    logic       run;
    logic [2:0] ph;
    logic [6:0] tt;
    logic [6:0] ct;
    logic [2:0] w;
    logic       bz;
  } exp_t;

  exp_t  sb[$];
  int    n_run  = 0;
  int    n_fail = 0;
  string cur_test = "init";

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0d, expected %0d", cur_test, tag, got, exp);
    end
  endtask

  // Reference model: program as an ordered list of phases.
  bit         m_on, m_idle, m_done, m_paused, m_buzz;
  int         m_idx, m_el, m_rem, m_tot, m_bcnt;
  logic [1:0] m_mode;

  function automatic logic [2:0] prog_phase(input logic [1:0] m, input int i);
    case (m)
      2'd0: case (i) 0: return 2; 1: return 3; 2: return 4; 3: return 2;
                     4: return 5; 5: return 4; 6: return 6; default: return 7; endcase
      2'd1: case (i) 0: return 2; 1: return 3; 2: return 4; default: return 7; endcase
      2'd2: case (i) 0: return 2; 1: return 5; 2: return 4; 3: return 6; default: return 7; endcase
      default: return (i == 0) ? 3'd6 : 3'd7;
    endcase
  endfunction

  function automatic int plen(input logic [2:0] ph);
    case (ph)
      3'd2, 3'd4: return WF;
      3'd3:       return WASH_T;
      3'd5:       return RINSE_T;
      3'd6:       return SPIN_T;
      default:    return 0;
    endcase
  endfunction

  function automatic int ptot(input logic [1:0] m);
    int s = 0;
    for (int i = 0; i < 8; i++) s += plen(prog_phase(m, i));
    return s;
  endfunction

  task automatic model_clear();
    m_on = 0; m_idle = 0; m_done = 0; m_paused = 0; m_buzz = 0;
    m_idx = 0; m_el = 0; m_rem = 0; m_tot = 0; m_bcnt = 0; m_mode = 2'd0;
  endtask

  task automatic model_step(input bit p, input bit s, input bit t, input logic [1:0] md);
    if (p) begin
      if (!m_on) begin
        m_on = 1; m_idle = 1; m_tot = ptot(md);
      end else model_clear();
    end else if (!m_on) begin
    end else if (m_idle) begin
      m_tot = ptot(md);
      if (s) begin
        m_mode = md; m_idle = 0; m_idx = 0; m_el = 0; m_rem = m_tot; m_paused = 0;
      end
    end else if (m_done) begin
      if (s) begin
        m_done = 0; m_idle = 1; m_buzz = 0; m_tot = ptot(md);
      end else if (t && m_buzz) begin
        m_bcnt++;
        if (m_bcnt == BUZZ_T) m_buzz = 0;
      end
    end else begin
      if (s) m_paused = !m_paused;
      else if (t && !m_paused) begin
        m_el++; m_rem--;
        if (m_el == plen(prog_phase(m_mode, m_idx))) begin
          m_idx++; m_el = 0;
          if (prog_phase(m_mode, m_idx) == 3'd7) begin
            m_done = 1;
`ifdef BUZZER_EN
            m_buzz = 1; m_bcnt = 0;
`endif
          end
        end
      end
    end
  endtask

  function automatic exp_t model_out();
    exp_t e = '0;
    logic [2:0] ph;
    if (!m_on) return e;
    e.pl = 1'b1;
    if (m_idle) begin
      e.ph = 3'd1; e.tt = 7'(m_tot); e.ct = 7'(m_tot);
    end else if (m_done) begin
      e.ph = 3'd7; e.tt = 7'(m_tot); e.ct = 7'd0; e.bz = m_buzz;
    end else begin
      ph = prog_phase(m_mode, m_idx);
      e.ph = ph; e.tt = 7'(m_tot); e.ct = 7'(m_rem); e.run = !m_paused;
      case (ph)
        3'd2:       e.w = 3'(m_el);
        3'd4:       e.w = 3'(WF - m_el);
        3'd3, 3'd5: e.w = 3'(WF);
        default:    e.w = 3'd0;
      endcase
    end
    return e;
  endfunction

  // One clock with the given button/tick pattern, then compare.
  task automatic cyc(input bit p, input bit s, input bit t);
    exp_t e;
    bus.power_btn = p; bus.start_btn = s; bus.tick = t;
    model_step(p, s, t, bus.mode);
    sb.push_back(model_out());
    @(posedge clk);
    #1;
    bus.power_btn = 1'b0; bus.start_btn = 1'b0; bus.tick = 1'b0;
    if (sb.size() == 0) chk("sb_empty", 1, 0);
    else begin
      e = sb.pop_front();
      chk("power_light", bus.power_light, e.pl);
      chk("running", bus.running, e.run);
      chk("phase", bus.phase, e.ph);
      chk("total_time", bus.total_time, e.tt);
      chk("current_time", bus.current_time, e.ct);
      chk("current_water", bus.current_water, e.w);
      chk("buzzer", bus.buzzer, e.bz);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.power_btn = 1'b0; bus.start_btn = 1'b0; bus.tick = 1'b0; bus.mode = 2'd0;
    model_clear();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Reset in the middle of a count.
    cur_test = "reset";
    cyc(1, 0, 0); cyc(0, 1, 0); ticks(4);
    rst_n = 1'b0; model_clear();
    #2;
    chk("rst_phase", bus.phase, 0);
    chk("rst_power", bus.power_light, 0);
    chk("rst_time", bus.current_time, 0);
    chk("rst_total", bus.total_time, 0);
    chk("rst_water", bus.current_water, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    cur_test = "power_on";
    cyc(0, 0, 1);
    cyc(1, 0, 0);
    chk("t1_phase", bus.phase, 1);
    chk("t1_total", bus.total_time, 38);
    chk("t1_cur", bus.current_time, 38);

    cur_test = "mode1";
    bus.mode = 2'd1;
    cyc(0, 0, 1);
    chk("t2_idle_total", bus.total_time, 19);
    cyc(0, 1, 0);
    ticks(5);
    chk("t2_full", bus.current_water, 5);
    for (int i = 0; i < 14; i++) begin cyc(0, 0, 1); cyc(0, 0, 0); end
    chk("t2_phase", bus.phase, 7);
    chk("t2_cur", bus.current_time, 0);
    cyc(0, 1, 0);

    cur_test = "pause";
    bus.mode = 2'd0;
    cyc(0, 0, 0);
    cyc(0, 1, 0); ticks(7); cyc(0, 1, 0); ticks(10); cyc(0, 1, 0);
    chk("t3_cur", bus.current_time, 31);
    chk("t3_phase", bus.phase, 3);
    chk("t3_water", bus.current_water, 5);

    cur_test = "power_off";
    cyc(1, 0, 0); cyc(1, 0, 0);
    cyc(0, 1, 0); ticks(12);
    cyc(1, 1, 1);
    chk("t4_phase", bus.phase, 0);
    chk("t4_cur", bus.current_time, 0);
    cyc(1, 0, 0);
    chk("t4_total", bus.total_time, 38);

    cur_test = "start_tick";
    cyc(0, 1, 0); ticks(3);
    cyc(0, 1, 1);
    chk("t5_running", bus.running, 0);
    chk("t5_cur", bus.current_time, 35);
    ticks(2);
    cyc(0, 1, 0);
    bus.mode = 2'd3;
    ticks(35);
    chk("t5_done", bus.phase, 7);
    chk("t5_total_held", bus.total_time, 38);

    cur_test = "mode2";
    bus.mode = 2'd2;
    cyc(0, 1, 0); cyc(0, 0, 0);
    cyc(0, 1, 0); ticks(19);
    chk("m2_done", bus.phase, 7);
    cyc(0, 1, 0);

    cur_test = "buzzer";
    bus.mode = 2'd3;
    cyc(0, 0, 0);
    cyc(0, 1, 0); ticks(3);
    chk("t6_phase", bus.phase, 7);
`ifdef BUZZER_EN
    chk("t6_buzz_on", bus.buzzer, 1);
    ticks(4);
    chk("t6_buzz_4", bus.buzzer, 1);
    ticks(1);
    chk("t6_buzz_off", bus.buzzer, 0);
`else
    ticks(5);
    chk("t6_buzz_tied", bus.buzzer, 0);
`endif
    cyc(0, 1, 0);
    cyc(0, 1, 0); ticks(3); ticks(2);
    cyc(0, 1, 0);
    chk("t6_ack_buzz", bus.buzzer, 0);
    chk("t6_ack_phase", bus.phase, 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
